// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register and operand-select stage of the RV32I core.
// Captures decode outputs, bypasses WB writes into the stored operands,
// forwards EX/MEM and MEM/WB results onto the registered source operands,
// and produces the ALU operands, store data, branch target and the
// load-use stall request.
module ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [3:0]        id_alu_op,
  input  logic [1:0]        id_a_sel,
  input  logic              id_b_sel,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_is_branch,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_result,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [REG_AW-1:0] ex_rd,
  output logic [3:0]        ex_alu_op,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_is_branch,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [XLEN-1:0]   ex_branch_target,
  output logic              load_use_stall
);

  // Stage state
  logic              valid_q,      valid_d;
  logic [XLEN-1:0]   pc_q,         pc_d;
  logic [REG_AW-1:0] rs1_q,        rs1_d;
  logic [REG_AW-1:0] rs2_q,        rs2_d;
  logic [REG_AW-1:0] rd_q,         rd_d;
  logic [XLEN-1:0]   rs1_data_q,   rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q,   rs2_data_d;
  logic [XLEN-1:0]   imm_q,        imm_d;
  logic [3:0]        alu_op_q,     alu_op_d;
  logic [1:0]        a_sel_q,      a_sel_d;
  logic              b_sel_q,      b_sel_d;
  logic              reg_write_q,  reg_write_d;
  logic              mem_read_q,   mem_read_d;
  logic              mem_write_q,  mem_write_d;
  logic              is_branch_q,  is_branch_d;

  // WB match helpers for capture-time bypass and stall-time refresh
  logic              wb_hit_id_rs1, wb_hit_id_rs2;
  logic              wb_hit_q_rs1,  wb_hit_q_rs2;
  logic [XLEN-1:0]   fwd_rs1, fwd_rs2;

  // WB destination comparisons; x0 is never a valid bypass source
  always_comb begin
    wb_hit_id_rs1 = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1);
    wb_hit_id_rs2 = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2);
    wb_hit_q_rs1  = wb_reg_write && (wb_rd != '0) && (wb_rd == rs1_q);
    wb_hit_q_rs2  = wb_reg_write && (wb_rd != '0) && (wb_rd == rs2_q);
  end

  // Load-use hazard: a load in EX whose destination decode is about to read.
  // Deliberately ignores whether decode actually uses rs1/rs2.
  always_comb begin
    load_use_stall = valid_q && mem_read_q && (rd_q != '0) && id_valid &&
                     ((rd_q == id_rs1) || (rd_q == id_rs2));
  end

  // Next-state selection: flush > stall > load-use bubble > normal capture
  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    alu_op_d    = alu_op_q;
    a_sel_d     = a_sel_q;
    b_sel_d     = b_sel_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    is_branch_d = is_branch_q;

    if (flush || (!stall && load_use_stall)) begin
      // Bubble: clear the whole slot so no stale operand can leak forward
      valid_d     = 1'b0;
      pc_d        = '0;
      rs1_d       = '0;
      rs2_d       = '0;
      rd_d        = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
      alu_op_d    = 4'b0000;
      a_sel_d     = 2'b00;
      b_sel_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      is_branch_d = 1'b0;
    end else if (stall) begin
      // Hold, but absorb values retiring from WB so they are not lost
      if (wb_hit_q_rs1) rs1_data_d = wb_result;
      if (wb_hit_q_rs2) rs2_data_d = wb_result;
    end else begin
      valid_d     = id_valid;
      pc_d        = id_pc;
      rs1_d       = id_rs1;
      rs2_d       = id_rs2;
      rd_d        = id_rd;
      rs1_data_d  = wb_hit_id_rs1 ? wb_result : id_rs1_data;
      rs2_data_d  = wb_hit_id_rs2 ? wb_result : id_rs2_data;
      imm_d       = id_imm;
      alu_op_d    = id_alu_op;
      a_sel_d     = id_a_sel;
      b_sel_d     = id_b_sel;
      reg_write_d = id_reg_write && id_valid;
      mem_read_d  = id_mem_read  && id_valid;
      mem_write_d = id_mem_write && id_valid;
      is_branch_d = id_is_branch && id_valid;
    end
  end

  // Stage register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      alu_op_q    <= 4'b0000;
      a_sel_q     <= 2'b00;
      b_sel_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      is_branch_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      alu_op_q    <= alu_op_d;
      a_sel_q     <= a_sel_d;
      b_sel_q     <= b_sel_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      is_branch_q <= is_branch_d;
    end
  end

  // Operand forwarding: EX/MEM beats WB beats stored data; x0 never forwards
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == rs1_q)) begin
      fwd_rs1 = exm_result;
    end else if (wb_hit_q_rs1) begin
      fwd_rs1 = wb_result;
    end
    fwd_rs2 = rs2_data_q;
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == rs2_q)) begin
      fwd_rs2 = exm_result;
    end else if (wb_hit_q_rs2) begin
      fwd_rs2 = wb_result;
    end
  end

  // Operand selection, store data and branch target
  always_comb begin
    unique case (a_sel_q)
      2'b00:   alu_a = fwd_rs1;
      2'b01:   alu_a = pc_q;
      default: alu_a = '0;
    endcase
    alu_b            = b_sel_q ? imm_q : fwd_rs2;
    ex_store_data    = fwd_rs2;
    ex_branch_target = pc_q + imm_q;
  end

  // Registered outputs; control is re-gated by valid so a bubble never acts
  always_comb begin
    ex_valid     = valid_q;
    ex_pc        = pc_q;
    ex_rd        = rd_q;
    ex_alu_op    = alu_op_q;
    ex_reg_write = reg_write_q && valid_q;
    ex_mem_read  = mem_read_q  && valid_q;
    ex_mem_write = mem_write_q && valid_q;
    ex_is_branch = is_branch_q && valid_q;
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios followed by
// randomized traffic compared against a transaction-level reference model.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic [1:0]  id_a_sel;
  logic        id_b_sel;
  logic        id_reg_write, id_mem_read, id_mem_write, id_is_branch;
  logic        exm_reg_write;
  logic [4:0]  exm_rd;
  logic [31:0] exm_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_alu_op;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch;
  logic [31:0] alu_a, alu_b, ex_store_data, ex_branch_target;
  logic        load_use_stall;

  int n_checks = 0;
  int n_errors = 0;

  ex_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_a_sel(id_a_sel), .id_b_sel(id_b_sel), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_is_branch(id_is_branch), .exm_reg_write(exm_reg_write),
    .exm_rd(exm_rd), .exm_result(exm_result), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .wb_result(wb_result), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_is_branch(ex_is_branch),
    .alu_a(alu_a), .alu_b(alu_b), .ex_store_data(ex_store_data),
    .ex_branch_target(ex_branch_target), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction currently sitting in EX
  typedef struct {
    bit          valid;
    bit [31:0]   pc, imm, d1, d2;
    bit [4:0]    rs1, rs2, rd;
    bit [3:0]    op;
    bit [1:0]    asel;
    bit          bsel, rw, mr, mw, br;
  } slot_t;

  slot_t m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] resolve(input bit [4:0] rs, input bit [31:0] stored);
    if (rs == 0) return stored;
    if (exm_reg_write && exm_rd == rs) return exm_result;
    if (wb_reg_write && wb_rd == rs) return wb_result;
    return stored;
  endfunction

  function automatic bit model_lus();
    return m.valid && m.mr && m.rd != 0 && id_valid &&
           (m.rd == id_rs1 || m.rd == id_rs2);
  endfunction

  function automatic bit [31:0] wb_view(input bit [4:0] rs, input bit [31:0] d);
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return wb_result;
    return d;
  endfunction

  task automatic clear_model();
    m = '{default: 0};
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; id_valid = 0;
    id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_op = 0; id_a_sel = 0; id_b_sel = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_is_branch = 0;
    exm_reg_write = 0; exm_rd = 0; exm_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_result = 0;
  endtask

  task automatic rand_inputs();
    stall = ($urandom_range(0, 7) == 0);
    flush = ($urandom_range(0, 15) == 0);
    id_valid = ($urandom_range(0, 4) != 0);
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
    id_rd = 5'($urandom_range(0, 3));
    id_alu_op = 4'($urandom); id_a_sel = 2'($urandom); id_b_sel = 1'($urandom);
    id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0);
    id_mem_write = 1'($urandom); id_is_branch = 1'($urandom);
    exm_reg_write = 1'($urandom); exm_rd = 5'($urandom_range(0, 3)); exm_result = $urandom;
    wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_result = $urandom;
  endtask

  // Compare all outputs against the model for the current inputs, then
  // advance the model across one rising edge.
  task automatic cycle();
    bit [31:0] f1, f2, ea;
    bit lus;
    #1;
    f1  = resolve(m.rs1, m.d1);
    f2  = resolve(m.rs2, m.d2);
    ea  = (m.asel == 2'd0) ? f1 : (m.asel == 2'd1) ? m.pc : 32'd0;
    lus = model_lus();
    check("ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
    check("ctrl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch},
          {28'd0, m.valid & m.rw, m.valid & m.mr, m.valid & m.mw, m.valid & m.br});
    check("load_use_stall", {31'd0, load_use_stall}, {31'd0, lus});
    if (m.valid) begin
      check("ex_alu_op", {28'd0, ex_alu_op}, {28'd0, m.op});
      check("ex_pc", ex_pc, m.pc);
      check("ex_rd", {27'd0, ex_rd}, {27'd0, m.rd});
      check("alu_a", alu_a, ea);
      check("alu_b", alu_b, m.bsel ? m.imm : f2);
      check("ex_store_data", ex_store_data, f2);
      check("ex_branch_target", ex_branch_target, m.pc + m.imm);
    end
    @(posedge clk);
    if (flush || (!stall && lus)) begin
      clear_model();
    end else if (stall) begin
      m.d1 = wb_view(m.rs1, m.d1);
      m.d2 = wb_view(m.rs2, m.d2);
    end else begin
      m.valid = id_valid; m.pc = id_pc; m.imm = id_imm;
      m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
      m.d1 = wb_view(id_rs1, id_rs1_data);
      m.d2 = wb_view(id_rs2, id_rs2_data);
      m.op = id_alu_op; m.asel = id_a_sel; m.bsel = id_b_sel;
      m.rw = id_reg_write & id_valid; m.mr = id_mem_read & id_valid;
      m.mw = id_mem_write & id_valid; m.br = id_is_branch & id_valid;
    end
    @(negedge clk);
  endtask

  task automatic async_reset_check(input string tag);
    rst_n = 1'b0;
    #2;
    check({tag, ".ex_valid"}, {31'd0, ex_valid}, 32'd0);
    check({tag, ".alu_a"}, alu_a, 32'd0);
    check({tag, ".alu_b"}, alu_b, 32'd0);
    check({tag, ".ex_alu_op"}, {28'd0, ex_alu_op}, 32'd0);
    check({tag, ".ctrl"}, {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch}, 32'd0);
    check({tag, ".target"}, ex_branch_target, 32'd0);
    clear_model();
    rst_n = 1'b1;
    $display("reset %s: state cleared", tag);
  endtask

  initial begin
    idle_inputs();
    clear_model();
    rst_n = 1'b0;
    #1;
    async_reset_check("power_on");
    @(negedge clk);

    // ADD x3,x1,x2 with x1=5, x2=7
    id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_rd = 3; id_rs1_data = 5; id_rs2_data = 7;
    id_reg_write = 1; id_pc = 32'h40;
    cycle();
    idle_inputs();
    #1;
    check("add.alu_a", alu_a, 32'd5);
    check("add.alu_b", alu_b, 32'd7);
    check("add.alu_op", {28'd0, ex_alu_op}, 32'd0);
    check("add.reg_write", {31'd0, ex_reg_write}, 32'd1);
    $display("add x3,x1,x2: alu_a=%0d alu_b=%0d", alu_a, alu_b);

    // Both EX/MEM and WB target x1: EX/MEM wins; then neither matches
    exm_reg_write = 1; exm_rd = 1; exm_result = 32'h10;
    wb_reg_write = 1; wb_rd = 1; wb_result = 32'h20;
    #1;
    check("fwd.exm_priority", alu_a, 32'h10);
    exm_rd = 0; wb_rd = 0;
    #1;
    check("fwd.none", alu_a, 32'd5);
    $display("forward priority: alu_a=%h", alu_a);
    idle_inputs();
    cycle();

    // LW x4 then a consumer of x4
    id_valid = 1; id_rd = 4; id_rs1 = 1; id_mem_read = 1; id_reg_write = 1; id_b_sel = 1;
    cycle();
    idle_inputs();
    id_valid = 1; id_rs1 = 4; id_rs2 = 0; id_rd = 5; id_reg_write = 1;
    #1;
    check("lu.stall_req", {31'd0, load_use_stall}, 32'd1);
    cycle();
    check("lu.bubble", {31'd0, ex_valid}, 32'd0);
    check("lu.deassert", {31'd0, load_use_stall}, 32'd0);
    cycle();
    check("lu.capture_valid", {31'd0, ex_valid}, 32'd1);
    check("lu.capture_rd", {27'd0, ex_rd}, 32'd5);
    $display("load-use: bubble inserted, consumer captured rd=%0d", ex_rd);

    // Hold an instruction reading x2 while WB retires x2=0xABCD
    idle_inputs();
    id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_rd = 6; id_rs1_data = 3; id_rs2_data = 32'h1111;
    id_reg_write = 1;
    cycle();
    idle_inputs();
    stall = 1; wb_reg_write = 1; wb_rd = 2; wb_result = 32'hABCD;
    repeat (3) cycle();
    idle_inputs();
    #1;
    check("stall.refresh", alu_b, 32'hABCD);
    $display("stall refresh: alu_b=%h", alu_b);
    cycle();

    // flush together with stall, then BEQ target wrap
    id_valid = 1; id_reg_write = 1; id_rd = 7;
    cycle();
    stall = 1; flush = 1;
    cycle();
    check("flush.valid", {31'd0, ex_valid}, 32'd0);
    check("flush.reg_write", {31'd0, ex_reg_write}, 32'd0);
    check("flush.alu_op", {28'd0, ex_alu_op}, 32'd0);
    idle_inputs();
    id_valid = 1; id_pc = 32'h100; id_imm = 32'hFFFF_FFF0; id_is_branch = 1; id_alu_op = 4'b1010;
    cycle();
    idle_inputs();
    #1;
    check("beq.target", ex_branch_target, 32'h0000_00F0);
    check("beq.is_branch", {31'd0, ex_is_branch}, 32'd1);
    $display("flush+stall bubble; beq target=%h", ex_branch_target);

    // Randomized traffic with one asynchronous reset mid-stream
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      if (i == 700) begin
        #1;
        async_reset_check("mid_stream");
      end
      cycle();
    end
    $display("random: 1500 cycles compared against model");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register and operand-select stage of the RV32I core.
- Registers decode outputs, resolves data hazards by forwarding from EX/MEM and MEM/WB, and drives the ALU operands (a, b, alu_op) combinationally from registered state.
- Also produces store data, the branch target and the load-use stall request for the hazard unit.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold stage contents.
- flush  in  1  replace stage contents with a bubble.
- id_valid  in  1  decode slot holds a real instruction.
- id_pc  in  XLEN  instruction PC.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  REG_AW  register addresses.
- id_alu_op  in  4  ALU opcode (0000 ADD … 1001 AND, 1010–1111 branch compares).
- id_a_sel  in  2  operand A select: 00 rs1, 01 pc, 10 zero, 11 zero.
- id_b_sel  in  1  operand B select: 0 rs2, 1 imm.
- id_reg_write, id_mem_read, id_mem_write, id_is_branch  in  1  control.
- exm_reg_write  in  1  EX/MEM writes a register.
- exm_rd  in  REG_AW  EX/MEM destination.
- exm_result  in  XLEN  EX/MEM value.
- wb_reg_write  in  1  WB writes a register.
- wb_rd  in  REG_AW  WB destination.
- wb_result  in  XLEN  WB value.
- ex_valid  out  1  stage holds a real instruction.
- ex_pc  out  XLEN  registered PC.
- ex_rd  out  REG_AW  registered destination.
- ex_alu_op  out  4  registered opcode; feeds the ALU alu_op.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch  out  1  registered control, gated by valid.
- alu_a, alu_b  out  XLEN  forwarded, selected ALU operands.
- ex_store_data  out  XLEN  forwarded rs2 value.
- ex_branch_target  out  XLEN  ex_pc + ex_imm.
- load_use_stall  out  1  request to stall fetch/decode.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers clear to 0.
  - ex_valid=0 and all control outputs 0.
  - ex_alu_op=0000; alu_a, alu_b, ex_store_data, ex_branch_target evaluate from zeroed state, giving 0.
- Capture priority at each rising edge:
  - flush, then stall, then load_use_stall, then normal.
  - flush: bubble (valid=0, control=0, alu_op=0000). Flush overrides stall.
  - stall without flush: hold all fields (see stall refresh below).
  - load_use_stall without stall/flush: capture a bubble. The hazard unit holds ID for that cycle.
  - Otherwise: capture all id_* fields; ex_valid<=id_valid; control bits ANDed with id_valid.
- WB bypass at capture: if wb_reg_write and wb_rd!=0 and wb_rd==id_rs1, the stored rs1 data is wb_result, not id_rs1_data. Same rule for rs2.
- Stall refresh: while held, if wb_reg_write and wb_rd!=0 and wb_rd matches the stored rs1 (or rs2), the stored data updates to wb_result. This prevents losing a value that retires during a stall.
- Forwarding (combinational, on registered rs1/rs2):
  - EX/MEM match (exm_reg_write, exm_rd!=0, exm_rd==rs) wins over a WB match, which wins over stored data.
  - Register x0 is never forwarded.
- Operand selection:
  - alu_a = fwd_rs1, ex_pc or 0, per a_sel.
  - alu_b = fwd_rs2 or ex_imm, per b_sel.
  - ex_store_data = fwd_rs2 regardless of b_sel.
- ex_branch_target = ex_pc + ex_imm, modulo 2^XLEN; carry discarded.
- load_use_stall = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - Conservative: does not check operand usage.
  - Combinational; deasserts the cycle after the bubble is inserted.
- Latency: 1 cycle from decode to registered outputs; operand outputs are combinational within the EX cycle.
- Mid-operation reset: clears immediately, without waiting for a clock edge; no pending state survives.

Test Plan:
- Reset with rst_n=0 mid-stream -> ex_valid=0, alu_a=alu_b=0, ex_alu_op=0000 asynchronously; first capture after release is a normal capture.
- ADD x3,x1,x2 with x1=5, x2=7, no hazards -> next cycle alu_a=5, alu_b=7, ex_alu_op=0000, ex_reg_write=1.
- Back-to-back hazard: exm_rd=1, exm_result=0x10, wb_rd=1, wb_result=0x20 -> alu_a=0x10 (EX/MEM priority); with exm_rd=0 and wb_rd=0 -> stored data used, no forward.
- LW x4 in EX, decode reads x4 -> load_use_stall=1; next edge ex_valid=0; following cycle stall deasserts and the dependent op captures.
- stall=1 for 3 cycles while WB writes x2=0xABCD -> the held instruction's alu_b=0xABCD after release, with no EX/MEM match.
- flush=1 together with stall=1 -> bubble inserted; BEQ with pc=0x100, imm=0xFFFFFFF0 -> ex_branch_target=0x000000F0.
